// File: rtl/seven_seg_pkg.sv
// Shared constants for the front-panel seven-segment display path.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int          NUM_DIGITS = 6;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  localparam logic [6:0]  SEG_OFF    = 7'b1111111;
  localparam logic [5:0]  AN_OFF     = 6'b111111;

  localparam logic [6:0]  GLYPH_0    = 7'b1000000;
  localparam logic [6:0]  GLYPH_1    = 7'b1111001;
  localparam logic [6:0]  GLYPH_2    = 7'b0100100;
  localparam logic [6:0]  GLYPH_3    = 7'b0110000;
  localparam logic [6:0]  GLYPH_4    = 7'b0011001;
  localparam logic [6:0]  GLYPH_5    = 7'b0010010;
  localparam logic [6:0]  GLYPH_6    = 7'b0000010;
  localparam logic [6:0]  GLYPH_7    = 7'b1111000;
  localparam logic [6:0]  GLYPH_8    = 7'b0000000;
  localparam logic [6:0]  GLYPH_9    = 7'b0010000;
  localparam logic [6:0]  GLYPH_A    = 7'b0001000;
  localparam logic [6:0]  GLYPH_B    = 7'b0000011;
  localparam logic [6:0]  GLYPH_C    = 7'b1000110;
  localparam logic [6:0]  GLYPH_D    = 7'b0100001;
  localparam logic [6:0]  GLYPH_E    = 7'b0000110;
  localparam logic [6:0]  GLYPH_F    = 7'b0001110;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex to seven-segment decoder, active-low outputs. Purely combinational
// so it can be shared by other display paths.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // full hex decode of the 4-bit code to its glyph
  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Six-digit display multiplexer: picks one digit code by mux_sel and
// registers code, glyph, anode strobe and blank flag on the same edge.
module seven_seg_mux
  import seven_seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in0,
  input  logic [3:0] data_in1,
  input  logic [3:0] data_in2,
  input  logic [3:0] data_in3,
  input  logic [3:0] data_in4,
  input  logic [3:0] data_in5,
  input  logic [2:0] mux_sel,
  output logic [3:0] data_out,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       blank
);

  logic [3:0] next_code;
  logic [5:0] next_an;
  logic       next_blank;
  logic [6:0] dec_seg;
  logic [6:0] next_seg;

  // select the digit code and its anode strobe; selects 6-7 blank the panel
  always_comb begin
    next_code  = BLANK_CODE;
    next_an    = AN_OFF;
    next_blank = 1'b1;
    case (mux_sel)
      3'd0: begin next_code = data_in0; next_an = 6'b111110; next_blank = 1'b0; end
      3'd1: begin next_code = data_in1; next_an = 6'b111101; next_blank = 1'b0; end
      3'd2: begin next_code = data_in2; next_an = 6'b111011; next_blank = 1'b0; end
      3'd3: begin next_code = data_in3; next_an = 6'b110111; next_blank = 1'b0; end
      3'd4: begin next_code = data_in4; next_an = 6'b101111; next_blank = 1'b0; end
      3'd5: begin next_code = data_in5; next_an = 6'b011111; next_blank = 1'b0; end
      default: ;
    endcase
  end

  seven_seg_decoder u_decoder (
    .code (next_code),
    .seg  (dec_seg)
  );

  // BLANK_CODE decodes to the F glyph, so an out-of-range select must
  // force the segments off rather than rely on the decoder
  always_comb begin
    next_seg = next_blank ? SEG_OFF : dec_seg;
  end

  // single output bank so all four outputs move on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 4'h0;
      seg      <= SEG_OFF;
      an       <= AN_OFF;
      blank    <= 1'b1;
    end else begin
      data_out <= next_code;
      seg      <= next_seg;
      an       <= next_an;
      blank    <= next_blank;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench for seven_seg_mux: expected outputs are pushed when
// stimulus is driven and popped one clock later when the outputs are sampled.
module tb_seven_seg_mux;

  typedef struct packed {
    logic [3:0] code;
    logic [6:0] seg;
    logic [5:0] an;
    logic       blank;
  } exp_t;

  localparam exp_t RST_VAL = '{code: 4'h0, seg: 7'b1111111, an: 6'b111111, blank: 1'b1};

  logic       clk;
  logic       rst_n;
  logic [3:0] din [6];
  logic [2:0] mux_sel;
  logic [3:0] data_out;
  logic [6:0] seg;
  logic [5:0] an;
  logic       blank;

  exp_t sb_q [$];
  int   vectors;
  int   miscompares;

  seven_seg_mux dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in0 (din[0]),
    .data_in1 (din[1]),
    .data_in2 (din[2]),
    .data_in3 (din[3]),
    .data_in4 (din[4]),
    .data_in5 (din[5]),
    .mux_sel  (mux_sel),
    .data_out (data_out),
    .seg      (seg),
    .an       (an),
    .blank    (blank)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic exp_t model_next();
    exp_t e;
    if (mux_sel < 3'd6) begin
      e.code  = din[mux_sel];
      e.seg   = glyph(din[mux_sel]);
      e.an    = 6'b111111 & ~(6'b000001 << mux_sel);
      e.blank = 1'b0;
    end else begin
      e.code  = 4'hF;
      e.seg   = 7'b1111111;
      e.an    = 6'b111111;
      e.blank = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t observed();
    return '{code: data_out, seg: seg, an: an, blank: blank};
  endfunction

  task automatic test_reset();
    exp_t o;
    rst_n   = 1'b0;
    mux_sel = 3'd3;
    for (int i = 0; i < 6; i++) din[i] = 4'(i + 7);
    repeat (2) @(posedge clk);
    #1;
    o = observed();
    vectors++;
    if (o !== RST_VAL) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", o, RST_VAL);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_select_sweep();
    logic [3:0] vals [6] = '{4'd3, 4'd7, 4'd1, 4'd9, 4'd0, 4'd5};
    exp_t e, o;
    for (int i = 0; i < 6; i++) din[i] = vals[i];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mux_sel = 3'(k);
      sb_q.push_back(model_next());
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL sweep sel=%0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    exp_t e, o;
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      mux_sel = 3'(k);
      sb_q.push_back(model_next());
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL out_of_range sel=%0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_hex_glyphs();
    exp_t e, o;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      mux_sel = 3'd2;
      din[2]  = 4'(c);
      sb_q.push_back(model_next());
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL hex_glyph code=%0h: got %h expected %h", c, o, e);
      end
    end
  endtask

  task automatic test_coherence();
    exp_t e, o;
    exp_t fixed = '{code: 4'h8, seg: 7'b0000000, an: 6'b101111, blank: 1'b0};
    @(negedge clk);
    mux_sel = 3'd0;
    din[4]  = 4'd2;
    sb_q.push_back(model_next());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = observed();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL coherence_pre: got %h expected %h", o, e);
    end
    @(negedge clk);
    mux_sel = 3'd4;
    din[4]  = 4'd8;
    sb_q.push_back(model_next());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = observed();
    vectors++;
    if (o !== fixed) begin
      miscompares++;
      $display("FAIL coherence_switch: got %h expected %h", o, fixed);
    end
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL coherence_model: got %h expected %h", o, e);
    end
  endtask

  task automatic test_async_reset();
    exp_t o;
    @(negedge clk);
    mux_sel = 3'd1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    o = observed();
    vectors++;
    if (o !== RST_VAL) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", o, RST_VAL);
    end
    @(posedge clk);
    #1;
    o = observed();
    vectors++;
    if (o !== RST_VAL) begin
      miscompares++;
      $display("FAIL reset_held_edge: got %h expected %h", o, RST_VAL);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_after_reset();
    exp_t e, o;
    @(negedge clk);
    mux_sel = 3'd5;
    din[5]  = 4'hE;
    sb_q.push_back(model_next());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = observed();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL first_edge_after_reset: got %h expected %h", o, e);
    end
  endtask

  task automatic test_random();
    exp_t e, o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int d = 0; d < 6; d++) din[d] = 4'($urandom % 10);
      mux_sel = 3'(i);
      sb_q.push_back(model_next());
      @(posedge clk);
      #1;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL random_iter=%0d: scoreboard empty, got %h expected entry", i, observed());
      end else begin
        e = sb_q.pop_front();
        o = observed();
        if (o !== e) begin
          miscompares++;
          $display("FAIL random_iter=%0d sel=%0d: got %h expected %h", i, mux_sel, o, e);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    mux_sel     = 3'd0;
    for (int i = 0; i < 6; i++) din[i] = 4'h0;
    test_reset();
    test_select_sweep();
    test_out_of_range();
    test_hex_glyphs();
    test_coherence();
    test_async_reset();
    test_after_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
